// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  // Fetch controller state: no request, request in flight, or in flight but discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // One buffered fetch result: the word and the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a PC onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with a flush input.
// Clear wins over push and pop; the storage array itself is never reset
// because its contents are only observed through a non-empty head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_reg;
  assign rdata   = mem[rd_ptr_reg];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: issues one sequential word request at a time
// to a handshaked memory, buffers {pc, instr} results and hands them to the
// IF stage. A taken-branch redirect flushes the buffer and restarts fetch;
// a request already on the bus is never retracted, its response is dropped.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_reg;
  fetch_state_e  state_next;
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   fetch_pc_next;
  logic [31:0]   req_addr_reg;
  logic [31:0]   req_addr_next;
  logic [31:0]   target;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          credit;
  logic          empty;
  logic          full;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;

  assign target   = align_pc(redirect_pc_i);
  assign pop      = ~empty & instr_ready_i & ~redirect_i;
  assign push     = (state_reg == REQ) & mem_ack_i & ~redirect_i;
  assign wr_entry = {req_addr_reg, mem_data_i};

  // A new request may only go out if its response is guaranteed a slot.
  // A full queue without a pop never has room, whatever count_next says.
  assign count_next = count + CW'(push) - CW'(pop);
  assign credit     = (count_next < CW'(DEPTH)) & ~(full & ~pop);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clear (redirect_i),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Fetch state, next fetch address and in-flight address registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_addr_reg <= req_addr_next;
    end
  end

  // Next-state logic; a redirect overrides everything else.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_addr_next = req_addr_reg;
    if (redirect_i) begin
      if (state_reg == IDLE || mem_ack_i) begin
        state_next    = REQ;
        req_addr_next = target;
        fetch_pc_next = target + PC_STEP;
      end else begin
        // Old request still pending: wait for its ack, then fetch the target.
        state_next    = DROP;
        fetch_pc_next = target;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (credit) begin
            state_next    = REQ;
            req_addr_next = fetch_pc_reg;
            fetch_pc_next = fetch_pc_reg + PC_STEP;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            if (credit) begin
              req_addr_next = fetch_pc_reg;
              fetch_pc_next = fetch_pc_reg + PC_STEP;
            end else begin
              state_next = IDLE;
            end
          end
        end
        DROP: begin
          if (mem_ack_i) begin
            state_next    = REQ;
            req_addr_next = fetch_pc_reg;
            fetch_pc_next = fetch_pc_reg + PC_STEP;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign mem_req_o     = (state_reg != IDLE);
  assign mem_addr_o    = req_addr_reg;
  assign instr_valid_o = ~empty;
  assign instr_o       = instr_valid_o ? head.instr : NOP_INSTR;
  assign pc_o          = instr_valid_o ? head.pc : 32'h0000_0000;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a queue-based model of the
// fetch front-end is compared against the DUT every cycle, plus directed
// literal expectations for the key scenarios.
module tb_inst_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        instr_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Model: buffered results, whether a request is outstanding, whether its
  // response is to be thrown away, the bus address and the next fetch address.
  ent_t        mq[$];
  bit          m_busy;
  bit          m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_fpc;

  // Memory responder: 0 = ack tied high, 1 = counted latency, 2 = driven by hand.
  int          mem_mode = 2;
  int          lat_min  = 0;
  int          lat_max  = 0;
  int          wait_left = 0;
  int          hs_cnt   = 0;
  logic [31:0] data_key = '0;
  bit          cmp_en   = 1'b0;

  inst_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_drop = 1'b0;
    m_addr = '0;
    m_fpc  = RESET_PC;
  endtask

  // One clock edge of the model, from the inputs the DUT is about to sample.
  task automatic model_step();
    logic [31:0] tgt;
    bit          take;
    bit          done;
    take = (mq.size() > 0) && instr_ready_i && !redirect_i;
    if (redirect_i) begin
      tgt = {redirect_pc_i[31:2], 2'b00};
      mq.delete();
      if (!m_busy || mem_ack_i) begin
        m_busy = 1'b1;
        m_drop = 1'b0;
        m_addr = tgt;
        m_fpc  = tgt + PC_STEP;
      end else begin
        m_drop = 1'b1;
        m_fpc  = tgt;
      end
    end else begin
      done = m_busy && mem_ack_i;
      if (done && !m_drop) mq.push_back('{pc: m_addr, instr: mem_data_i});
      if (take) void'(mq.pop_front());
      if (done) begin
        m_busy = 1'b0;
        m_drop = 1'b0;
      end
      if (!m_busy && mq.size() < DEPTH) begin
        m_busy = 1'b1;
        m_addr = m_fpc;
        m_fpc  = m_fpc + PC_STEP;
      end
    end
  endtask

  task automatic mem_drive();
    mem_data_i = mem_addr_o ^ data_key;
    case (mem_mode)
      0: mem_ack_i = 1'b1;
      1: begin
        if (mem_req_o) begin
          if (wait_left == 0) begin
            mem_ack_i = 1'b1;
            wait_left = int'($urandom_range(lat_max, lat_min));
          end else begin
            mem_ack_i = 1'b0;
            wait_left--;
          end
        end else begin
          mem_ack_i = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  // Advance one cycle: step the model just before the edge, respond after it.
  task automatic tick();
    @(negedge clk_i);
    #1;
    if (!rst_i) model_reset();
    else model_step();
    if (rst_i && mem_req_o && mem_ack_i) hs_cnt++;
    @(posedge clk_i);
    #2;
    mem_drive();
  endtask

  task automatic do_reset();
    rst_i      = 1'b0;
    redirect_i = 1'b0;
    mem_ack_i  = 1'b0;
    model_reset();
    wait_left  = lat_min;
    hs_cnt     = 0;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("mem_req_o", 32'(mem_req_o), 32'(m_busy));
      check("mem_addr_o", mem_addr_o, m_addr);
      check("instr_valid_o", 32'(instr_valid_o), 32'(mq.size() > 0));
      check("pc_o", pc_o, (mq.size() > 0) ? mq[0].pc : 32'h0);
      check("instr_o", instr_o, (mq.size() > 0) ? mq[0].instr : NOP_INSTR);
    end
  end

  initial begin
    #2;
    // Reset values
    do_reset();
    cmp_en = 1'b1;
    check("rst_req", 32'(mem_req_o), 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_valid", 32'(instr_valid_o), 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);

    // Zero-wait memory returning its address, consumer always ready
    mem_mode = 0; instr_ready_i = 1'b1; data_key = '0;
    do_reset();
    tick();
    check("zw_first_req", 32'(mem_req_o), 32'h1);
    check("zw_first_addr", mem_addr_o, 32'h0);
    check("zw_first_valid", 32'(instr_valid_o), 32'h0);
    tick();
    check("zw_pc0", pc_o, 32'h0);
    check("zw_valid0", 32'(instr_valid_o), 32'h1);
    check("zw_addr4", mem_addr_o, 32'h4);
    tick();
    check("zw_pc4", pc_o, 32'h4);
    check("zw_instr4", instr_o, 32'h4);
    tick();
    check("zw_pc8", pc_o, 32'h8);
    check("zw_addr12", mem_addr_o, 32'hC);
    repeat (8) tick();

    // Consumer stalled: exactly DEPTH fetches, then the bus goes quiet
    instr_ready_i = 1'b0;
    do_reset();
    repeat (10) tick();
    check("stall_handshakes", 32'(hs_cnt), 32'd4);
    check("stall_req_low", 32'(mem_req_o), 32'h0);
    check("stall_head_pc", pc_o, 32'h0);
    instr_ready_i = 1'b1;
    tick();
    check("resume_pc4", pc_o, 32'h4);
    check("resume_addr16", mem_addr_o, 32'h10);
    check("resume_req", 32'(mem_req_o), 32'h1);
    repeat (3) tick();
    check("resume_pc16", pc_o, 32'h10);
    repeat (4) tick();

    // Three-cycle memory latency
    mem_mode = 1; lat_min = 2; lat_max = 2; data_key = 32'hCAFE_0000;
    do_reset();
    tick();
    check("lat_addr_c1", mem_addr_o, 32'h0);
    tick();
    check("lat_addr_c2", mem_addr_o, 32'h0);
    check("lat_req_c2", 32'(mem_req_o), 32'h1);
    tick();
    check("lat_addr_c3", mem_addr_o, 32'h0);
    check("lat_valid_c3", 32'(instr_valid_o), 32'h0);
    tick();
    check("lat_addr_c4", mem_addr_o, 32'h4);
    check("lat_instr0", instr_o, 32'hCAFE_0000);
    repeat (30) tick();

    // Redirect while the request to 8 is still unacknowledged
    mem_mode = 2; data_key = 32'h5A5A_0000; instr_ready_i = 1'b1;
    do_reset();
    tick();
    mem_ack_i = 1'b1;
    tick();
    tick();
    mem_ack_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    tick();
    redirect_i = 1'b0;
    check("drop_valid", 32'(instr_valid_o), 32'h0);
    check("drop_addr_held", mem_addr_o, 32'h8);
    check("drop_req_held", 32'(mem_req_o), 32'h1);
    tick();
    check("drop_wait_addr", mem_addr_o, 32'h8);
    mem_ack_i = 1'b1;
    tick();
    check("drop_new_addr", mem_addr_o, 32'h100);
    check("drop_no_stale", 32'(instr_valid_o), 32'h0);
    tick();
    check("drop_head_pc", pc_o, 32'h100);
    check("drop_head_instr", instr_o, 32'h5A5A_0100);
    mem_ack_i = 1'b0;
    repeat (3) tick();

    // Redirect in the same cycle as an ack and a pop, two entries buffered
    instr_ready_i = 1'b0;
    do_reset();
    tick();
    mem_ack_i = 1'b1;
    tick();
    tick();
    check("rdack_pre_pc", pc_o, 32'h0);
    instr_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040;
    tick();
    redirect_i = 1'b0;
    check("rdack_valid", 32'(instr_valid_o), 32'h0);
    check("rdack_addr", mem_addr_o, 32'h40);
    tick();
    check("rdack_head", pc_o, 32'h40);
    mem_ack_i = 1'b0;
    repeat (3) tick();

    // PC wrap-around through a redirect near the top of the address space
    mem_mode = 0; instr_ready_i = 1'b1;
    do_reset();
    repeat (3) tick();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFB;
    tick();
    redirect_i = 1'b0;
    check("wrap_addr", mem_addr_o, 32'hFFFF_FFF8);
    check("wrap_flush", 32'(instr_valid_o), 32'h0);
    tick();
    check("wrap_pc_f8", pc_o, 32'hFFFF_FFF8);
    tick();
    check("wrap_pc_fc", pc_o, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc_0", pc_o, 32'h0);
    check("wrap_addr_4", mem_addr_o, 32'h4);

    // Randomized traffic: random latency, stalls and redirects
    mem_mode = 1; lat_min = 0; lat_max = 3; data_key = 32'h1357_9BDF;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      instr_ready_i = ($urandom_range(3, 0) != 0);
      redirect_i    = ($urandom_range(11, 0) == 0);
      if ($urandom_range(3, 0) == 0) redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      else redirect_pc_i = $urandom;
      if (i == 1500) mem_mode = 0;
      if (i == 2200) mem_mode = 1;
      tick();
    end
    redirect_i = 1'b0;
    repeat (4) tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front-end between a handshaked, variable-latency instruction memory and the pipelined CPU's IF/ID register. Keeps a fetch PC, issues one sequential word request at a time, and buffers returned {pc, instr} pairs in a small FIFO. The IF stage consumes from the FIFO under its stall signal. A taken-branch redirect flushes the queue and any in-flight response.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- mem_req_o  out  32-bit side: 1  request valid; held until acknowledged.
- mem_addr_o  out  32  word address of the current request.
- mem_ack_i  in  1  request complete; `mem_data_i` is valid in the same cycle.
- mem_data_i  in  32  instruction word returned by memory.
- instr_valid_o  out  1  FIFO head is valid.
- instr_o  out  32  head instruction; 32'h0 (NOP) when not valid.
- pc_o  out  32  PC of the head instruction; 32'h0 when not valid.
- instr_ready_i  in  1  consumer accepts the head this cycle (IF/ID write enable).
- redirect_i  in  1  branch taken; flush the queue and restart fetch.
- redirect_pc_i  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.

## Operation
- Registers: `fetch_pc` (next address to request), `req_addr` (address in flight), FIFO with `count` in 0..DEPTH, and state in {IDLE, REQ, DROP}.
- `mem_req_o` = (state != IDLE). `mem_addr_o` = `req_addr`. Both are registered.
- Pop: `instr_valid_o` & `instr_ready_i` & !`redirect_i`.
- Push: state == REQ & `mem_ack_i` & !`redirect_i`. Writes {`req_addr`, `mem_data_i`}.
- `count_next` = `count` + push − pop. Push and pop in the same cycle leave `count` unchanged.
- Credit: a request may be issued only if `count_next` < DEPTH. At most one request is outstanding, so overflow is impossible.
- State transitions when no redirect:
  - IDLE → REQ when credit is available: `req_addr` ← `fetch_pc`, `fetch_pc` += 4.
  - REQ with ack → REQ (back-to-back, same load of `req_addr`/`fetch_pc`) if credit is available, else IDLE.
  - REQ without ack → REQ. Address and request are held stable.
  - DROP with ack → REQ (load from `fetch_pc`); the response is discarded. Without ack, stay in DROP.
- Redirect (takes priority over push, pop and credit):
  - FIFO is cleared (`count` ← 0). `fetch_pc` ← {`redirect_pc_i`[31:2], 2'b00}.
  - From IDLE, or from REQ/DROP with `mem_ack_i` high: next state is REQ with `req_addr` ← redirect target and `fetch_pc` ← target + 4. Any acked data is discarded.
  - From REQ/DROP with `mem_ack_i` low: next state is DROP. A request is never retracted. `req_addr` holds the old address; `fetch_pc` holds the target.
- PC arithmetic is modulo 2^32; it wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset values: state IDLE, `count` 0, `fetch_pc` RESET_PC, `req_addr` 0. Outputs: `mem_req_o` 0, `mem_addr_o` 0, `instr_valid_o` 0, `instr_o` 0, `pc_o` 0.
- Reset asserted mid-request drops everything immediately. The memory must tolerate an abandoned request.
- First request: `mem_req_o` = 1 in the first cycle after the first clock edge following reset release.
- Ack at edge N → `instr_valid_o` = 1 in cycle N+1 when the FIFO was empty. There is no bypass path.
- Zero-wait memory (ack tied high) sustains one instruction per cycle into the consumer.
- Redirect sampled at edge N:
  - `instr_valid_o` = 0 in cycle N+1.
  - `mem_addr_o` = target in cycle N+1, unless the state went to DROP.
  - Earliest valid instruction from the target appears in cycle N+2 with zero-wait memory.
- Head outputs are stable while `instr_valid_o` & !`instr_ready_i`.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE, REQ, DROP), NOP_INSTR = 32'h0, PC_STEP = 32'd4, and a packed struct {pc, instr}.
- Sub-module `fetch_fifo`: synchronous FIFO of the struct with DEPTH parameter, push/pop/clear, count/empty/full outputs, and asynchronous active-low reset. Clear has priority over push and pop.

## Test plan
- Reset, ack tied 1, ready tied 1, memory returns {addr}: `mem_addr_o` goes 0, 4, 8… one per cycle; `pc_o`/`instr_o` go 0/0, 4/4, 8/8 starting two cycles after reset release.
- Ready held 0, zero-wait memory: exactly 4 pushes occur, then `mem_req_o` drops to 0. Ready raised → 4 sequential pops at PCs 0..12, and fetching resumes at 16.
- Memory with 3-cycle ack latency: `mem_addr_o` is held stable with req high for 3 cycles; each word appears in order; only one request is outstanding.
- Redirect to 32'h0000_0103 while a request to 8 is unacked: state goes to DROP, the late ack's data never appears, then a request to 32'h100 is issued and the head becomes pc 32'h100.
- Redirect in the same cycle as ack and pop with FIFO holding 2 entries: `instr_valid_o` is 0 next cycle, `mem_addr_o` = target next cycle, and no stale PC is ever output.
- `fetch_pc` seeded at 32'hFFFF_FFF8 via redirect: outputs PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
